sram_rw_arbiter: RTL and testbench

SRAM_RW_ARBITER -- requirements
Module: sram_rw_arbiter

---
 rtl/sram_rw_arbiter_pkg.sv | 8 +
 rtl/sram_wbuf.sv | 52 +++++
 rtl/sram_rw_arbiter.sv | 88 ++++++++
 tb/tb_sram_rw_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_rw_arbiter_pkg.sv
// SRAM geometry and arbiter defaults shared by the arbiter and the SRAM wrapper.
package sram_rw_arbiter_pkg;
    localparam int SRAM_SET_W        = 6;
    localparam int SRAM_DATA_W       = 64;
    localparam int SRAM_SETS         = 1 << SRAM_SET_W;
    localparam int SRAM_STARVE_LIMIT = 4;
    localparam int STARVE_W          = 3;
endpackage

// File: rtl/sram_wbuf.sv
// One-entry write buffer with a starvation counter that forces a drain
// once a buffered write has been held off by reads for too long.
module sram_wbuf
    import sram_rw_arbiter_pkg::*;
#(
    parameter int SET_W        = SRAM_SET_W,
    parameter int DATA_W       = SRAM_DATA_W,
    parameter int STARVE_LIMIT = SRAM_STARVE_LIMIT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              r_req_valid,
    input  logic              w_req_valid,
    input  logic [SET_W-1:0]  w_req_setIdx,
    input  logic [DATA_W-1:0] w_req_data,
    output logic              w_req_ready,
    output logic              drain,
    output logic              starved,
    output logic              wbuf_valid,
    output logic [SET_W-1:0]  wbuf_setIdx,
    output logic [DATA_W-1:0] wbuf_data
);
    logic [STARVE_W-1:0] starve;
    logic                w_fire;

    assign starved     = wbuf_valid && (starve == STARVE_W'(STARVE_LIMIT));
    assign drain       = wbuf_valid && (!r_req_valid || starved);
    assign w_req_ready = !wbuf_valid || drain;
    assign w_fire      = w_req_valid && w_req_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wbuf_valid  <= 1'b0;
            wbuf_setIdx <= '0;
            wbuf_data   <= '0;
            starve      <= '0;
        end else begin
            if (w_fire) begin
                wbuf_valid  <= 1'b1;
                wbuf_setIdx <= w_req_setIdx;
                wbuf_data   <= w_req_data;
            end else if (drain) begin
                wbuf_valid <= 1'b0;
            end
            // A drain always restarts the count, even when a new write reloads the entry.
            if (drain || !wbuf_valid)
                starve <= '0;
            else
                starve <= starve + STARVE_W'(1);
        end
    end
endmodule

// File: rtl/sram_rw_arbiter.sv
// Read/write arbiter in front of a single-port SRAM: reads have priority,
// writes are buffered, and reads hitting the buffered entry are forwarded.
module sram_rw_arbiter
    import sram_rw_arbiter_pkg::*;
#(
    parameter int SET_W        = SRAM_SET_W,
    parameter int DATA_W       = SRAM_DATA_W,
    parameter int STARVE_LIMIT = SRAM_STARVE_LIMIT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_r_req_valid,
    output logic              io_r_req_ready,
    input  logic [SET_W-1:0]  io_r_req_setIdx,
    output logic              io_r_resp_valid,
    output logic [DATA_W-1:0] io_r_resp_data,
    input  logic              io_w_req_valid,
    output logic              io_w_req_ready,
    input  logic [SET_W-1:0]  io_w_req_setIdx,
    input  logic [DATA_W-1:0] io_w_req_data,
    output logic              sram_rreq_valid,
    output logic [SET_W-1:0]  sram_rreq_setIdx,
    input  logic [DATA_W-1:0] sram_rresp_data,
    output logic              sram_wreq_valid,
    output logic [SET_W-1:0]  sram_wreq_setIdx,
    output logic [DATA_W-1:0] sram_wreq_data,
    output logic              io_wbuf_empty
);
    logic              drain;
    logic              starved;
    logic              wbuf_valid;
    logic [SET_W-1:0]  wbuf_setIdx;
    logic [DATA_W-1:0] wbuf_data;
    logic              r_fire;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [DATA_W-1:0] hold_data;
    logic [DATA_W-1:0] resp_sel;

    sram_wbuf #(
        .SET_W       (SET_W),
        .DATA_W      (DATA_W),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_wbuf (
        .clock       (clock),
        .reset       (reset),
        .r_req_valid (io_r_req_valid),
        .w_req_valid (io_w_req_valid),
        .w_req_setIdx(io_w_req_setIdx),
        .w_req_data  (io_w_req_data),
        .w_req_ready (io_w_req_ready),
        .drain       (drain),
        .starved     (starved),
        .wbuf_valid  (wbuf_valid),
        .wbuf_setIdx (wbuf_setIdx),
        .wbuf_data   (wbuf_data)
    );

    // A drain only happens with no read pending or with reads blocked, so the ports never collide.
    assign io_r_req_ready   = !starved;
    assign r_fire           = io_r_req_valid && io_r_req_ready && reset;
    assign sram_rreq_valid  = r_fire;
    assign sram_rreq_setIdx = io_r_req_setIdx;
    assign sram_wreq_valid  = drain;
    assign sram_wreq_setIdx = wbuf_setIdx;
    assign sram_wreq_data   = wbuf_data;
    assign io_wbuf_empty    = !wbuf_valid;

    assign resp_sel       = fwd_hit ? fwd_data : sram_rresp_data;
    assign io_r_resp_data = io_r_resp_valid ? resp_sel : hold_data;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_r_resp_valid <= 1'b0;
            fwd_hit         <= 1'b0;
            fwd_data        <= '0;
            hold_data       <= '0;
        end else begin
            io_r_resp_valid <= r_fire;
            // Compare against the pre-edge buffer so a same-cycle write stays invisible.
            fwd_hit <= r_fire && wbuf_valid && (wbuf_setIdx == io_r_req_setIdx);
            if (r_fire)
                fwd_data <= wbuf_data;
            if (io_r_resp_valid)
                hold_data <= resp_sel;
        end
    end
endmodule

// File: tb/tb_sram_rw_arbiter.sv
// Directed bench for sram_rw_arbiter with an SRAM model and read/write scoreboards.
module tb_sram_rw_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        io_r_req_valid = 1'b0;
    logic        io_r_req_ready;
    logic [5:0]  io_r_req_setIdx = '0;
    logic        io_r_resp_valid;
    logic [63:0] io_r_resp_data;
    logic        io_w_req_valid = 1'b0;
    logic        io_w_req_ready;
    logic [5:0]  io_w_req_setIdx = '0;
    logic [63:0] io_w_req_data = '0;
    logic        sram_rreq_valid;
    logic [5:0]  sram_rreq_setIdx;
    logic [63:0] sram_rresp_data;
    logic        sram_wreq_valid;
    logic [5:0]  sram_wreq_setIdx;
    logic [63:0] sram_wreq_data;
    logic        io_wbuf_empty;

    int checks = 0;
    int errors = 0;

    logic [63:0] mem[64];
    logic [63:0] exp_mem[64];
    logic [63:0] rq[$];
    logic [69:0] wq[$];

    sram_rw_arbiter dut (
        .clock           (clock),
        .reset           (reset),
        .io_r_req_valid  (io_r_req_valid),
        .io_r_req_ready  (io_r_req_ready),
        .io_r_req_setIdx (io_r_req_setIdx),
        .io_r_resp_valid (io_r_resp_valid),
        .io_r_resp_data  (io_r_resp_data),
        .io_w_req_valid  (io_w_req_valid),
        .io_w_req_ready  (io_w_req_ready),
        .io_w_req_setIdx (io_w_req_setIdx),
        .io_w_req_data   (io_w_req_data),
        .sram_rreq_valid (sram_rreq_valid),
        .sram_rreq_setIdx(sram_rreq_setIdx),
        .sram_rresp_data (sram_rresp_data),
        .sram_wreq_valid (sram_wreq_valid),
        .sram_wreq_setIdx(sram_wreq_setIdx),
        .sram_wreq_data  (sram_wreq_data),
        .io_wbuf_empty   (io_wbuf_empty)
    );

    always #5 clock = ~clock;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 64'h1000 + 64'(i);
        mem[7] = 64'h77;
        for (int i = 0; i < 64; i++) exp_mem[i] = mem[i];
    end

    always @(posedge clock) begin
        if (sram_wreq_valid) mem[sram_wreq_setIdx] <= sram_wreq_data;
        if (sram_rreq_valid) sram_rresp_data <= mem[sram_rreq_setIdx];
    end

    task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push on accepted requests, pop when the DUT produces output.
    always @(negedge clock) begin
        if (reset) begin
            chk("port_exclusive", 70'(sram_rreq_valid && sram_wreq_valid), 70'd0);
            if (io_r_resp_valid) begin
                if (rq.size() == 0) chk("unexpected_resp", 70'd1, 70'd0);
                else chk("resp_data", 70'(io_r_resp_data), 70'(rq.pop_front()));
            end
            if (sram_wreq_valid) begin
                if (wq.size() == 0) chk("unexpected_sram_write", 70'd1, 70'd0);
                else chk("sram_write", {sram_wreq_setIdx, sram_wreq_data}, wq.pop_front());
            end
            if (io_r_req_valid && io_r_req_ready) begin
                chk("sram_rreq", {63'd0, sram_rreq_valid, sram_rreq_setIdx},
                    {63'd0, 1'b1, io_r_req_setIdx});
                rq.push_back(exp_mem[io_r_req_setIdx]);
            end
            if (io_w_req_valid && io_w_req_ready) begin
                wq.push_back({io_w_req_setIdx, io_w_req_data});
                exp_mem[io_w_req_setIdx] = io_w_req_data;
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        io_r_req_valid = 1'b0;
        io_w_req_valid = 1'b0;
    endtask

    task automatic rd(input logic [5:0] idx);
        io_r_req_valid  = 1'b1;
        io_r_req_setIdx = idx;
    endtask

    task automatic wr(input logic [5:0] idx, input logic [63:0] data);
        io_w_req_valid  = 1'b1;
        io_w_req_setIdx = idx;
        io_w_req_data   = data;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_resp_valid"}, 70'(io_r_resp_valid), 70'd0);
        chk({tag, "_resp_data"}, 70'(io_r_resp_data), 70'd0);
        chk({tag, "_wbuf_empty"}, 70'(io_wbuf_empty), 70'd1);
        chk({tag, "_sram_valids"}, 70'({sram_rreq_valid, sram_wreq_valid}), 70'd0);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk_reset_state("reset");
        cyc();
        reset = 1'b1;
        cyc();

        // Single write drains on the following cycle.
        wr(6'd5, 64'hA5);
        @(negedge clock);
        chk("w_ready_idle", 70'(io_w_req_ready), 70'd1);
        cyc(); idle();
        @(negedge clock);
        chk("drain_valid", 70'(sram_wreq_valid), 70'd1);
        chk("wbuf_full", 70'(io_wbuf_empty), 70'd0);
        cyc();
        @(negedge clock);
        chk("wbuf_empty_after", 70'(io_wbuf_empty), 70'd1);
        chk("no_more_write", 70'(sram_wreq_valid), 70'd0);

        // Read hits the buffered entry and is forwarded.
        wr(6'd3, 64'h11);
        cyc(); idle();
        rd(6'd3);
        @(negedge clock);
        chk("fwd_r_ready", 70'(io_r_req_ready), 70'd1);
        chk("fwd_no_write", 70'(sram_wreq_valid), 70'd0);
        cyc(); idle();
        @(negedge clock);
        chk("fwd_resp_valid", 70'(io_r_resp_valid), 70'd1);
        chk("fwd_resp_data", 70'(io_r_resp_data), 70'h11);
        cyc();

        // Starvation: continuous reads block on the fifth cycle to let the write out.
        wr(6'd40, 64'hBEEF);
        cyc(); idle();
        for (int k = 1; k <= 7; k++) begin
            rd(6'd9);
            @(negedge clock);
            chk("starve_r_ready", 70'(io_r_req_ready), 70'(k != 5));
            chk("starve_drain", 70'(sram_wreq_valid), 70'(k == 5));
            cyc();
        end
        idle();
        cyc();

        // Hold register keeps the last result through idle cycles.
        rd(6'd7);
        cyc(); idle();
        @(negedge clock);
        chk("r7_pulse", 70'(io_r_resp_valid), 70'd1);
        chk("r7_data", 70'(io_r_resp_data), 70'h77);
        for (int k = 0; k < 10; k++) begin
            cyc();
            @(negedge clock);
            chk("hold_valid_low", 70'(io_r_resp_valid), 70'd0);
            chk("hold_data", 70'(io_r_resp_data), 70'h77);
        end
        cyc();

        // Back-to-back writes drain in order.
        wr(6'd1, 64'hD1);
        cyc();
        wr(6'd2, 64'hD2);
        @(negedge clock);
        chk("b2b_w_ready", 70'(io_w_req_ready), 70'd1);
        chk("b2b_first_idx", 70'({sram_wreq_valid, sram_wreq_setIdx}), {63'd0, 1'b1, 6'd1});
        cyc(); idle();
        @(negedge clock);
        chk("b2b_second_idx", 70'({sram_wreq_valid, sram_wreq_setIdx}), {63'd0, 1'b1, 6'd2});
        cyc();

        // Same-cycle write and read to one index: the read sees the old value.
        wr(6'd12, 64'hC0C0);
        rd(6'd12);
        cyc(); idle();
        @(negedge clock);
        chk("same_cycle_old", 70'(io_r_resp_data), 70'h100C);
        cyc();
        rd(6'd12);
        cyc(); rd(6'd40);
        cyc(); idle();
        repeat (3) cyc();

        // Reset with a read and a write in flight discards both.
        wr(6'd20, 64'hDEAD);
        rd(6'd7);
        cyc();
        reset = 1'b0;
        idle();
        rq.delete();
        wq.delete();
        @(negedge clock);
        chk_reset_state("midreset");
        cyc();
        reset = 1'b1;
        for (int i = 0; i < 64; i++) exp_mem[i] = mem[i];
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk_reset_state("post_reset");
            cyc();
        end
        rd(6'd20);
        cyc(); idle();
        @(negedge clock);
        chk("discarded_write", 70'(io_r_resp_data), 70'h1014);
        repeat (2) cyc();

        chk("rq_drained", 70'(rq.size()), 70'd0);
        chk("wq_drained", 70'(wq.size()), 70'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
